uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16: stop-bit duration in s_tick units; legal values 16, 24, 32.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_tick  input  1  one-clk-wide enable pulse at 16x the baud rate.
REQ-008 fifo_empty  input  1  TX FIFO empty flag.
REQ-009 fifo_data  input  DBIT  TX FIFO head word; valid whenever fifo_empty=0.
REQ-010 fifo_rd  output  1  one-clk pop strobe to the TX FIFO.
REQ-011 tx  output  1  serial line; idle high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tx_done_tick  output  1  one-clk pulse when a frame's stop period completes.

Function
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; only PARITY_EN=1 reaches PARITY.
REQ-015 Tick counter s_cnt, 5 bits: increments only on clk edges where s_tick=1; cleared on every state change.
REQ-016 Bit counter n_cnt, 3 bits: counts data bits sent.
REQ-017 IDLE: tx=1. Exit condition is fifo_empty=0.
REQ-018 On exit from IDLE, in the same cycle:
  - assert fifo_rd for exactly 1 clk;
  - load shift register b_reg with fifo_data;
  - load parity register with XOR of fifo_data[DBIT-1:0], inverted when PARITY_ODD=1;
  - go to START.
REQ-019 fifo_rd SHALL never assert while fifo_empty=1 and SHALL assert once per frame.
REQ-020 START: tx=0. Go to DATA with n_cnt=0 on the s_tick where s_cnt=15, giving 16 ticks.
REQ-021 DATA: tx=b_reg[0], LSB first.
  - On the s_tick where s_cnt=15: shift b_reg right by one and increment n_cnt.
  - When n_cnt=DBIT-1 at that point: go to PARITY if PARITY_EN=1, else STOP.
REQ-022 PARITY: tx=parity register for 16 ticks, then go to STOP.
REQ-023 STOP: tx=1 for SB_TICK ticks.
  - On the s_tick where s_cnt=SB_TICK-1: assert tx_done_tick for 1 clk and go to IDLE.
REQ-024 Frame length in ticks = 16*(1+DBIT+PARITY_EN) + SB_TICK.
REQ-025 Back-to-back frames: with fifo_empty=0 in the cycle after tx_done_tick, the next START begins exactly 1 clk later; tx stays 1 in between.
REQ-026 fifo_data changes while not in IDLE SHALL NOT affect the frame in progress.
REQ-027 tx SHALL be driven from a register, with no combinational glitches.
REQ-028 s_tick with no FIFO data leaves the block in IDLE with tx=1.

Reset
REQ-029 While rst=1, the following SHALL hold immediately, independent of clk:
  - state=IDLE;
  - s_cnt=0, n_cnt=0, b_reg=0;
  - tx=1, busy=0, fifo_rd=0, tx_done_tick=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame: tx returns high at once, and no tx_done_tick is produced.
REQ-031 After rst deasserts, the first frame starts only when fifo_empty=0; the aborted word is not retransmitted.

Verification
REQ-032 Defaults; push 0xA5 with s_tick every 16 clk.
  - Required: fifo_rd one pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks.
  - Required: tx_done_tick one pulse after 160 ticks; busy high throughout.
REQ-033 PARITY_EN=1, PARITY_ODD=0; send 0x07.
  - Required: parity bit=1.
  - Repeat with PARITY_ODD=1: parity bit=0; frame 176 ticks.
REQ-034 FIFO holds 0x11, 0x22, 0x33 back-to-back.
  - Required: three fifo_rd pulses, one per frame; frames contiguous with 1-clk idle gaps; three tx_done_tick pulses.
REQ-035 Assert rst during DATA bit 3 of 0x5A.
  - Required: tx=1 and busy=0 asynchronously; no tx_done_tick.
  - Required: after release, the next FIFO word is sent intact.
REQ-036 DBIT=7, SB_TICK=32; send 0x7F.
  - Required: 7 data bits of 1; stop high 32 ticks; total 160 ticks.
REQ-037 fifo_empty=1 for 1000 clk with s_tick running.
  - Required: fifo_rd never asserts; tx=1 and busy=0 throughout.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one word from a TX FIFO and serialises it as
// start bit, DBIT data bits (LSB first), optional parity bit, and stop period.
// Ports: clk/rst (async, active-high); s_tick 16x baud enable;
//        fifo_empty/fifo_data/fifo_rd FIFO head and pop strobe;
//        tx serial line (registered, idle high); busy; tx_done_tick end of frame.
module uart_tx_engine #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);
  localparam logic       PAR_INV   = (PARITY_ODD != 0);

  state_t          state, state_next;
  logic [4:0]      s_cnt, s_cnt_next;
  logic [2:0]      n_cnt, n_cnt_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            par_reg, par_next;
  logic            tx_reg, tx_next;
  logic            pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_cnt   <= '0;
      n_cnt   <= '0;
      b_reg   <= '0;
      par_reg <= 1'b0;
      tx_reg  <= 1'b1;
    end else begin
      state   <= state_next;
      s_cnt   <= s_cnt_next;
      n_cnt   <= n_cnt_next;
      b_reg   <= b_next;
      par_reg <= par_next;
      tx_reg  <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    s_cnt_next   = s_tick ? s_cnt + 5'd1 : s_cnt;
    n_cnt_next   = n_cnt;
    b_next       = b_reg;
    par_next     = par_reg;
    pop          = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        s_cnt_next = '0;
        if (!fifo_empty) begin
          // Word and its parity are captured here, so later changes on
          // fifo_data cannot disturb the frame in flight.
          pop        = 1'b1;
          b_next     = fifo_data;
          par_next   = (^fifo_data) ^ PAR_INV;
          state_next = START;
        end
      end
      START: begin
        if (s_tick && s_cnt == BIT_LAST) begin
          state_next = DATA;
          s_cnt_next = '0;
          n_cnt_next = '0;
        end
      end
      DATA: begin
        if (s_tick && s_cnt == BIT_LAST) begin
          // Bit boundaries inside DATA also restart the tick count.
          s_cnt_next = '0;
          b_next     = b_reg >> 1;
          n_cnt_next = n_cnt + 3'd1;
          if (n_cnt == DATA_LAST)
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (s_tick && s_cnt == BIT_LAST) begin
          state_next = STOP;
          s_cnt_next = '0;
        end
      end
      STOP: begin
        if (s_tick && s_cnt == STOP_LAST) begin
          tx_done_tick = 1'b1;
          state_next   = IDLE;
          s_cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        s_cnt_next = '0;
      end
    endcase

    // Line level is decided from the next state so the tx flop changes on
    // the same edge as the state register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  // Gated with rst so no pop can escape while reset is held with data waiting.
  assign fifo_rd = pop & ~rst;
  assign tx      = tx_reg;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: four instances cover default framing,
// even/odd parity, and DBIT=7 with a 32-tick stop; s_tick every 16 clk.
// Each frame is checked mid-bit against hand-computed line levels.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_tick = 1'b0;
  logic       fempty [4];
  logic [7:0] fdat   [4];
  logic       rd_w   [4];
  logic       tx_w   [4];
  logic       busy_w [4];
  logic       done_w [4];
  int         rd_cnt [4];
  int         done_cnt [4];
  int         bad_rd [4];
  int         errors = 0;
  int         checks = 0;
  int         tdiv = 0;

  uart_tx_engine u0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(fempty[0]), .fifo_data(fdat[0]),
    .fifo_rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done_tick(done_w[0]));

  uart_tx_engine #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(fempty[1]), .fifo_data(fdat[1]),
    .fifo_rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done_tick(done_w[1]));

  uart_tx_engine #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(fempty[2]), .fifo_data(fdat[2]),
    .fifo_rd(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done_tick(done_w[2]));

  uart_tx_engine #(.DBIT(7), .SB_TICK(32)) u3 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(fempty[3]), .fifo_data(fdat[3][6:0]),
    .fifo_rd(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done_tick(done_w[3]));

  always #5 clk = ~clk;

  // s_tick changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    tdiv   = (tdiv == 15) ? 0 : tdiv + 1;
    s_tick = (tdiv == 15);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rd_w[k] === 1'b1) begin
        rd_cnt[k]++;
        if (fempty[k] !== 1'b0) bad_rd[k]++;
      end
      if (done_w[k] === 1'b1) done_cnt[k]++;
    end
  end

  // Returns #1 after the n-th rising edge at which s_tick is high.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  // exp holds start/data/parity line levels, first-sent bit in exp[0].
  task automatic run_frame(input int k, input logic [7:0] word, input int nbits,
                           input logic [11:0] exp, input int stop_ticks, input bit b2b,
                           input bit more, input logic [7:0] next_word, input string name);
    int r0, d0, waited;
    bit got;
    r0 = rd_cnt[k];
    d0 = done_cnt[k];
    fdat[k]   = word;
    fempty[k] = 1'b0;
    got = 0;
    waited = 0;
    while (!got && waited < 64) begin
      @(negedge clk);
      waited++;
      if (rd_w[k] === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s pop: no fifo_rd within 64 clk, required one", name);
      fempty[k] = 1'b1;
      return;
    end
    if (b2b) begin
      checks++;
      if (waited != 1 || tx_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s gap: pop after %0d clk with tx=%b, required 1 clk with tx=1", name, waited, tx_w[k]);
      end
    end
    @(posedge clk);
    #1;
    // The FIFO head moves on right away; the frame must not notice.
    if (more) fdat[k] = next_word;
    else begin
      fempty[k] = 1'b1;
      fdat[k]   = ~word;
    end
    for (int b = 0; b < nbits; b++) begin
      wait_ticks(8);
      checks++;
      if (tx_w[k] !== exp[b] || busy_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s bit%0d: tx=%b busy=%b, required tx=%b busy=1", name, b, tx_w[k], busy_w[k], exp[b]);
      end
      wait_ticks(8);
    end
    wait_ticks(stop_ticks / 2);
    checks++;
    if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s stop: tx=%b busy=%b, required tx=1 busy=1", name, tx_w[k], busy_w[k]);
    end
    wait_ticks(stop_ticks / 2 - 1);
    checks++;
    if (done_cnt[k] !== d0) begin
      errors++;
      $display("FAIL %s early_done: %0d done pulses, required 0", name, done_cnt[k] - d0);
    end
    wait_ticks(1);
    checks++;
    if (done_cnt[k] !== d0 + 1 || busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s end: done=%0d busy=%b tx=%b, required done=1 busy=0 tx=1",
               name, done_cnt[k] - d0, busy_w[k], tx_w[k]);
    end
    checks++;
    if (rd_cnt[k] !== r0 + 1) begin
      errors++;
      $display("FAIL %s pops: %0d fifo_rd pulses, required 1", name, rd_cnt[k] - r0);
    end
  endtask

  // Reset is raised before the first clock edge, so the values seen here
  // can only come from the asynchronous reset path.
  task automatic test_reset();
    fempty[0] = 1'b0;
    fdat[0]   = 8'h3C;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || rd_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: tx=%b busy=%b fifo_rd=%b done=%b, required 1 0 0 0",
                 k, tx_w[k], busy_w[k], rd_w[k], done_w[k]);
      end
    end
    fempty[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_frame(0, 8'hA5, 9, 12'h14A, 16, 1'b0, 1'b0, 8'h00, "a5");
  endtask

  task automatic test_parity();
    run_frame(1, 8'h07, 10, 12'h20E, 16, 1'b0, 1'b0, 8'h00, "par_even");
    run_frame(2, 8'h07, 10, 12'h00E, 16, 1'b0, 1'b0, 8'h00, "par_odd");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'h11, 9, 12'h022, 16, 1'b0, 1'b1, 8'h22, "b2b_11");
    run_frame(0, 8'h22, 9, 12'h044, 16, 1'b1, 1'b1, 8'h33, "b2b_22");
    run_frame(0, 8'h33, 9, 12'h066, 16, 1'b1, 1'b0, 8'h00, "b2b_33");
  endtask

  task automatic test_rst_mid_frame();
    int r0, d0, waited;
    r0 = rd_cnt[0];
    d0 = done_cnt[0];
    fdat[0]   = 8'h5A;
    fempty[0] = 1'b0;
    waited = 0;
    while (rd_w[0] !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    fempty[0] = 1'b1;
    fdat[0]   = 8'hFF;
    wait_ticks(16 + 3 * 16 + 8);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid bit3: tx=%b busy=%b, required tx=1 busy=1", tx_w[0], busy_w[0]);
    end
    #2;
    rst = 1'b1;
    fempty[0] = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rd_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: tx=%b busy=%b fifo_rd=%b, required 1 0 0", tx_w[0], busy_w[0], rd_w[0]);
    end
    fempty[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (done_cnt[0] !== d0 || rd_cnt[0] !== r0 + 1 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid after: done=%0d pops=%0d tx=%b busy=%b, required 0 1 1 0",
               done_cnt[0] - d0, rd_cnt[0] - r0, tx_w[0], busy_w[0]);
    end
    run_frame(0, 8'hC3, 9, 12'h186, 16, 1'b0, 1'b0, 8'h00, "post_rst_c3");
  endtask

  task automatic test_dbit7();
    run_frame(3, 8'h7F, 8, 12'h0FE, 32, 1'b0, 1'b0, 8'h00, "dbit7");
  endtask

  task automatic test_idle();
    int viol, r0;
    viol = 0;
    r0 = rd_cnt[0];
    repeat (1000) begin
      @(negedge clk);
      if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0 || rd_cnt[0] !== r0) begin
      errors++;
      $display("FAIL idle: %0d bad cycles and %0d pops, required 0 and 0", viol, rd_cnt[0] - r0);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      fempty[k] = 1'b1;
      fdat[k]   = 8'h00;
    end
    #2;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_rst_mid_frame();
    test_dbit7();
    test_idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bad_rd[k] != 0) begin
        errors++;
        $display("FAIL pop_when_empty dut%0d: %0d pulses, required 0", k, bad_rd[k]);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
